// File: rtl/vga_timing_pkg.sv
// Shared timing constants and elaboration helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Bit order of the three signals carried through the delay line.
    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic on_screen;
    } sync_bits_t;

    function automatic int h_total(input int visible, input int front, input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int v_total(input int visible, input int front, input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // A field must keep at least one bit even when it only ever holds 0.
    function automatic int width_of(input int value);
        return (clog2(value) == 0) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that keeps sync/blanking aligned with downstream
// pipeline latency. DEPTH = 0 is a combinational pass-through.
module vga_delay_line #(
    parameter int              WIDTH     = 3,
    parameter int              DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             n_reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        assign dout = din;
    end else begin : g_shift
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;
        logic [DEPTH-1:0][WIDTH-1:0] stage_d;

        always_comb begin
            stage_d = stage_q;
            if (en) begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
            end
        end

        // NOTE: every stage is reset so the sync outputs sit at their idle level, never X, out of reset.
        always_ff @(posedge CLK or negedge n_reset) begin
            if (!n_reset) stage_q <= {DEPTH{RESET_VAL}};
            else          stage_q <= stage_d;
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel/line counters, character-cell coordinates
// with a multiplier-free linear address, and pipeline-aligned sync/blanking outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CELL_W     = 8,
    parameter int CELL_H     = 16,
    parameter int PIPE_DELAY = 2,
    parameter int CNT_W      = 11,
    parameter int ADDR_W     = 12,
    parameter int CX_W       = width_of(CELL_W),
    parameter int CY_W       = width_of(CELL_H)
) (
    input  logic              CLK,
    input  logic              n_reset,
    input  logic              en,
    output logic [CNT_W-1:0]  x,
    output logic [CNT_W-1:0]  y,
    output logic [CNT_W-1:0]  col,
    output logic [CNT_W-1:0]  row,
    output logic [CX_W-1:0]   cell_x,
    output logic [CY_W-1:0]   cell_y,
    output logic [ADDR_W-1:0] char_addr,
    output logic              active,
    output logic              line_start,
    output logic              frame_start,
    output logic              h_sync,
    output logic              v_sync,
    output logic              on_screen
);

    localparam int   H_TOTAL  = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int   V_TOTAL  = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int   COLS     = H_VISIBLE / CELL_W;
    localparam int   ROWS     = V_VISIBLE / CELL_H;
    localparam int   HS_START = H_VISIBLE + H_FRONT;
    localparam int   HS_END   = HS_START + H_SYNC;
    localparam int   VS_START = V_VISIBLE + V_FRONT;
    localparam int   VS_END   = VS_START + V_SYNC;
    localparam logic HPOL     = 1'(H_SYNC_POL);
    localparam logic VPOL     = 1'(V_SYNC_POL);

    if (H_VISIBLE % CELL_W != 0) begin : g_err_cell_w
        $error("CELL_W must divide H_VISIBLE");
    end
    if (V_VISIBLE % CELL_H != 0) begin : g_err_cell_h
        $error("CELL_H must divide V_VISIBLE");
    end
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_err_cnt_w
        $error("H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end
    if (COLS * ROWS > (1 << ADDR_W)) begin : g_err_addr_w
        $error("character map does not fit in ADDR_W bits");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_err_pipe
        $error("PIPE_DELAY must be in 0..15");
    end

    logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
    logic [CX_W-1:0]   cell_x_q, cell_x_d;
    logic [CY_W-1:0]   cell_y_q, cell_y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              x_wrap, y_wrap;

    assign x_wrap = (x_q == CNT_W'(H_TOTAL - 1));
    assign y_wrap = (y_q == CNT_W'(V_TOTAL - 1));

    // NOTE: hold values are assigned first so no path leaves a signal unassigned (no latches).
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        col_d      = col_q;
        row_d      = row_q;
        cell_x_d   = cell_x_q;
        cell_y_d   = cell_y_q;
        row_base_d = row_base_q;

        if (en) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = y_wrap ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end

            // Cell counters look at the next position so they agree with x/y after the edge.
            if (x_d == '0 || x_d >= CNT_W'(H_VISIBLE)) begin
                cell_x_d = '0;
                col_d    = '0;
            end else if (cell_x_q == CX_W'(CELL_W - 1)) begin
                cell_x_d = '0;
                col_d    = col_q + CNT_W'(1);
            end else begin
                cell_x_d = cell_x_q + CX_W'(1);
            end

            if (x_wrap) begin
                if (y_d == '0 || y_d >= CNT_W'(V_VISIBLE)) begin
                    cell_y_d   = '0;
                    row_d      = '0;
                    row_base_d = '0;
                end else if (cell_y_q == CY_W'(CELL_H - 1)) begin
                    cell_y_d   = '0;
                    row_d      = row_q + CNT_W'(1);
                    row_base_d = row_base_q + ADDR_W'(COLS);
                end else begin
                    cell_y_d = cell_y_q + CY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge n_reset) begin
        if (!n_reset) begin
            x_q        <= '0;
            y_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            cell_x_q   <= '0;
            cell_y_q   <= '0;
            row_base_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cell_x_q   <= cell_x_d;
            cell_y_q   <= cell_y_d;
            row_base_q <= row_base_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign col         = col_q;
    assign row         = row_q;
    assign cell_x      = cell_x_q;
    assign cell_y      = cell_y_q;
    assign char_addr   = row_base_q + ADDR_W'(col_q);
    assign active      = (x_q < CNT_W'(H_VISIBLE)) && (y_q < CNT_W'(V_VISIBLE));
    assign line_start  = (x_q == '0);
    assign frame_start = (x_q == '0) && (y_q == '0);

    sync_bits_t raw_bits, dly_bits;
    logic       hs_raw, vs_raw;

    assign hs_raw = (x_q >= CNT_W'(HS_START)) && (x_q < CNT_W'(HS_END));
    assign vs_raw = (y_q >= CNT_W'(VS_START)) && (y_q < CNT_W'(VS_END));

    always_comb begin
        raw_bits           = '0;
        raw_bits.h_sync    = hs_raw ? HPOL : ~HPOL;
        raw_bits.v_sync    = vs_raw ? VPOL : ~VPOL;
        raw_bits.on_screen = active;
    end

    vga_delay_line #(
        .WIDTH     ($bits(sync_bits_t)),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL ({~HPOL, ~VPOL, 1'b0})
    ) u_delay (
        .CLK     (CLK),
        .n_reset (n_reset),
        .en      (en),
        .din     (raw_bits),
        .dout    (dly_bits)
    );

    assign h_sync    = dly_bits.h_sync;
    assign v_sync    = dly_bits.v_sync;
    assign on_screen = dly_bits.on_screen;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four differently parametrised generators compared every cycle
// against an arithmetic raster model, plus tabled cell-math points and timing sequences.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, hpol, vpol, cw, ch, pd;
    } mode_t;

    typedef struct packed {
        int x, y, col, row, cx, cy, addr, act, ls, fs, hs, vs, on;
    } obs_t;

    typedef struct {
        int tx, ty;
        int col, row, cx, cy, addr;
    } vec_t;

    logic CLK = 1'b0;
    logic n_reset;
    logic en_a, en_b;
    int   vectors = 0;
    int   miscompares = 0;
    int   n_a, n_b;
    mode_t m_d0, m_d3, m_sm, m_md;

    always #5 CLK = ~CLK;

    // Enabled edges since reset, per enable domain: the model's only state.
    always @(posedge CLK or negedge n_reset) begin
        if (!n_reset) begin
            n_a <= 0;
            n_b <= 0;
        end else begin
            if (en_a) n_a <= n_a + 1;
            if (en_b) n_b <= n_b + 1;
        end
    end

    logic [10:0] d0_x, d0_y, d0_col, d0_row, d3_x, d3_y, d3_col, d3_row;
    logic [10:0] s_x, s_y, s_col, s_row, md_x, md_y, md_col, md_row;
    logic [2:0]  d0_cx, d3_cx, md_cx;
    logic [3:0]  d0_cy, d3_cy, md_cy;
    logic [0:0]  s_cx, s_cy;
    logic [11:0] d0_addr, d3_addr, s_addr, md_addr;
    logic d0_act, d0_ls, d0_fs, d0_hs, d0_vs, d0_on;
    logic d3_act, d3_ls, d3_fs, d3_hs, d3_vs, d3_on;
    logic s_act, s_ls, s_fs, s_hs, s_vs, s_on;
    logic md_act, md_ls, md_fs, md_hs, md_vs, md_on;

    vga_timing_gen #(.PIPE_DELAY(0)) u_d0 (
        .CLK(CLK), .n_reset(n_reset), .en(en_a),
        .x(d0_x), .y(d0_y), .col(d0_col), .row(d0_row), .cell_x(d0_cx), .cell_y(d0_cy),
        .char_addr(d0_addr), .active(d0_act), .line_start(d0_ls), .frame_start(d0_fs),
        .h_sync(d0_hs), .v_sync(d0_vs), .on_screen(d0_on)
    );

    vga_timing_gen #(.PIPE_DELAY(3)) u_d3 (
        .CLK(CLK), .n_reset(n_reset), .en(en_a),
        .x(d3_x), .y(d3_y), .col(d3_col), .row(d3_row), .cell_x(d3_cx), .cell_y(d3_cy),
        .char_addr(d3_addr), .active(d3_act), .line_start(d3_ls), .frame_start(d3_fs),
        .h_sync(d3_hs), .v_sync(d3_vs), .on_screen(d3_on)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CELL_W(2), .CELL_H(1), .PIPE_DELAY(2)
    ) u_sm (
        .CLK(CLK), .n_reset(n_reset), .en(en_b),
        .x(s_x), .y(s_y), .col(s_col), .row(s_row), .cell_x(s_cx), .cell_y(s_cy),
        .char_addr(s_addr), .active(s_act), .line_start(s_ls), .frame_start(s_fs),
        .h_sync(s_hs), .v_sync(s_vs), .on_screen(s_on)
    );

    vga_timing_gen #(
        .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(32), .V_FRONT(2), .V_SYNC(3), .V_BACK(3),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .CELL_W(8), .CELL_H(16), .PIPE_DELAY(1)
    ) u_md (
        .CLK(CLK), .n_reset(n_reset), .en(en_b),
        .x(md_x), .y(md_y), .col(md_col), .row(md_row), .cell_x(md_cx), .cell_y(md_cy),
        .char_addr(md_addr), .active(md_act), .line_start(md_ls), .frame_start(md_fs),
        .h_sync(md_hs), .v_sync(md_vs), .on_screen(md_on)
    );

    function automatic obs_t mk_obs(input int x, y, col, row, cx, cy, addr, act, ls, fs, hs, vs, on);
        obs_t o;
        o = '{x: x, y: y, col: col, row: row, cx: cx, cy: cy, addr: addr,
              act: act, ls: ls, fs: fs, hs: hs, vs: vs, on: on};
        return o;
    endfunction

    obs_t g_d0, g_d3, g_sm, g_md;
    always_comb g_d0 = mk_obs(d0_x, d0_y, d0_col, d0_row, d0_cx, d0_cy, d0_addr, d0_act, d0_ls, d0_fs, d0_hs, d0_vs, d0_on);
    always_comb g_d3 = mk_obs(d3_x, d3_y, d3_col, d3_row, d3_cx, d3_cy, d3_addr, d3_act, d3_ls, d3_fs, d3_hs, d3_vs, d3_on);
    always_comb g_sm = mk_obs(s_x, s_y, s_col, s_row, s_cx, s_cy, s_addr, s_act, s_ls, s_fs, s_hs, s_vs, s_on);
    always_comb g_md = mk_obs(md_x, md_y, md_col, md_row, md_cx, md_cy, md_addr, md_act, md_ls, md_fs, md_hs, md_vs, md_on);

    // Raster position and undelayed sync/active after n enabled edges.
    task automatic raw_at(input mode_t m, input int n, output int x, output int y,
                          output int hs, output int vs, output int act);
        int ht, vt, p;
        ht  = m.hv + m.hf + m.hs + m.hb;
        vt  = m.vv + m.vf + m.vs + m.vb;
        p   = n % (ht * vt);
        x   = p % ht;
        y   = p / ht;
        hs  = (x >= m.hv + m.hf && x < m.hv + m.hf + m.hs) ? m.hpol : 1 - m.hpol;
        vs  = (y >= m.vv + m.vf && y < m.vv + m.vf + m.vs) ? m.vpol : 1 - m.vpol;
        act = (x < m.hv && y < m.vv) ? 1 : 0;
    endtask

    task automatic expect_at(input mode_t m, input int n, output obs_t e);
        int x, y, hs, vs, act, dx, dy, dact;
        raw_at(m, n, x, y, hs, vs, act);
        e.x    = x;
        e.y    = y;
        e.col  = (x < m.hv) ? x / m.cw : 0;
        e.cx   = (x < m.hv) ? x % m.cw : 0;
        e.row  = (y < m.vv) ? y / m.ch : 0;
        e.cy   = (y < m.vv) ? y % m.ch : 0;
        e.addr = e.row * (m.hv / m.cw) + e.col;
        e.act  = act;
        e.ls   = (x == 0) ? 1 : 0;
        e.fs   = (x == 0 && y == 0) ? 1 : 0;
        if (n < m.pd) begin
            e.hs = 1 - m.hpol;
            e.vs = 1 - m.vpol;
            e.on = 0;
        end else begin
            raw_at(m, n - m.pd, dx, dy, e.hs, e.vs, dact);
            e.on = dact;
        end
    endtask

    task automatic cmp(input string name, input int n, input obs_t got, input obs_t exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got x=%0d y=%0d col=%0d row=%0d cx=%0d cy=%0d addr=%0d act=%0d ls=%0d fs=%0d hs=%0d vs=%0d on=%0d | want x=%0d y=%0d col=%0d row=%0d cx=%0d cy=%0d addr=%0d act=%0d ls=%0d fs=%0d hs=%0d vs=%0d on=%0d",
                     name, n, got.x, got.y, got.col, got.row, got.cx, got.cy, got.addr, got.act, got.ls, got.fs, got.hs, got.vs, got.on,
                     exp.x, exp.y, exp.col, exp.row, exp.cx, exp.cy, exp.addr, exp.act, exp.ls, exp.fs, exp.hs, exp.vs, exp.on);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic scoreboard();
        obs_t e;
        expect_at(m_d0, n_a, e); cmp("d0_model", n_a, g_d0, e);
        expect_at(m_d3, n_a, e); cmp("d3_model", n_a, g_d3, e);
        expect_at(m_sm, n_b, e); cmp("small_model", n_b, g_sm, e);
        expect_at(m_md, n_b, e); cmp("mid_model", n_b, g_md, e);
    endtask

    task automatic step(input logic ea, input logic eb);
        en_a = ea;
        en_b = eb;
        @(posedge CLK);
        @(negedge CLK);
        scoreboard();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int lo_cnt, lo_first, lo_last, fs_cnt;

        m_d0 = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
                 hpol: 0, vpol: 0, cw: 8, ch: 16, pd: 0};
        m_d3 = m_d0;
        m_d3.pd = 3;
        m_sm = '{hv: 4, hf: 1, hs: 2, hb: 1, vv: 3, vf: 1, vs: 1, vb: 1,
                 hpol: 0, vpol: 0, cw: 2, ch: 1, pd: 2};
        m_md = '{hv: 32, hf: 4, hs: 8, hb: 4, vv: 32, vf: 2, vs: 3, vb: 3,
                 hpol: 1, vpol: 1, cw: 8, ch: 16, pd: 1};

        // Default 640x480 mode, 80 columns: {x, y} -> {col, row, cell_x, cell_y, char_addr}.
        tbl[0]  = '{tx: 0,   ty: 0,  col: 0,  row: 0, cx: 0, cy: 0,  addr: 0};
        tbl[1]  = '{tx: 7,   ty: 0,  col: 0,  row: 0, cx: 7, cy: 0,  addr: 0};
        tbl[2]  = '{tx: 8,   ty: 0,  col: 1,  row: 0, cx: 0, cy: 0,  addr: 1};
        tbl[3]  = '{tx: 639, ty: 0,  col: 79, row: 0, cx: 7, cy: 0,  addr: 79};
        tbl[4]  = '{tx: 640, ty: 0,  col: 0,  row: 0, cx: 0, cy: 0,  addr: 0};
        tbl[5]  = '{tx: 799, ty: 0,  col: 0,  row: 0, cx: 0, cy: 0,  addr: 0};
        tbl[6]  = '{tx: 0,   ty: 1,  col: 0,  row: 0, cx: 0, cy: 1,  addr: 0};
        tbl[7]  = '{tx: 8,   ty: 16, col: 1,  row: 1, cx: 0, cy: 0,  addr: 81};
        tbl[8]  = '{tx: 9,   ty: 17, col: 1,  row: 1, cx: 1, cy: 1,  addr: 81};
        tbl[9]  = '{tx: 639, ty: 17, col: 79, row: 1, cx: 7, cy: 1,  addr: 159};
        tbl[10] = '{tx: 700, ty: 31, col: 0,  row: 1, cx: 0, cy: 15, addr: 80};
        tbl[11] = '{tx: 0,   ty: 32, col: 0,  row: 2, cx: 0, cy: 0,  addr: 160};

        n_reset = 1'b0;
        en_a    = 1'b0;
        en_b    = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_x", d0_x, 0);
        check("rst_y", d0_y, 0);
        check("rst_d3_hsync", d3_hs, 1);
        check("rst_d3_vsync", d3_vs, 1);
        check("rst_d3_on_screen", d3_on, 0);
        check("rst_frame_start", d0_fs, 1);
        n_reset = 1'b1;

        lo_cnt = 0; lo_first = -1; lo_last = -1; fs_cnt = 0;
        for (int i = 0; i <= 25600; i++) begin
            if (i > 0) step(1'b1, 1'b1);
            else scoreboard();
            if (i == 0) check("first_frame_start", d0_fs, 1);
            if (i < 800 && d0_hs == 1'b0) begin
                lo_cnt++;
                if (lo_first < 0) lo_first = i;
                lo_last = i;
            end
            if (i == 799) begin
                check("hsync_low_cycles", lo_cnt, 96);
                check("hsync_first_low_x", lo_first, 656);
                check("hsync_last_low_x", lo_last, 751);
            end
            if (i <= 3) check("on_screen_lat3", d3_on, (i == 3) ? 1 : 0);
            if (i == 658) check("d3_hsync_pre_fall", d3_hs, 1);
            if (i == 659) check("d3_hsync_fall", d3_hs, 0);
            if (i == 800) begin
                check("line_wrap_x", d0_x, 0);
                check("line_wrap_y", d0_y, 1);
                check("line_wrap_line_start", d0_ls, 1);
            end
            if (i < 144 && s_fs) fs_cnt++;
            if (i == 143) check("small_frame_starts_3_frames", fs_cnt, 3);
            if (i == 47) begin
                check("small_last_x", s_x, 7);
                check("small_last_y", s_y, 5);
            end
            if (i == 48) begin
                check("small_wrap_x", s_x, 0);
                check("small_wrap_y", s_y, 0);
                check("small_wrap_addr", s_addr, 0);
            end
            for (int t = 0; t < 12; t++) begin
                if (i == tbl[t].ty * 800 + tbl[t].tx) begin
                    check($sformatf("tbl%0d_col", t), d0_col, tbl[t].col);
                    check($sformatf("tbl%0d_row", t), d0_row, tbl[t].row);
                    check($sformatf("tbl%0d_cell_x", t), d0_cx, tbl[t].cx);
                    check($sformatf("tbl%0d_cell_y", t), d0_cy, tbl[t].cy);
                    check($sformatf("tbl%0d_addr", t), d0_addr, tbl[t].addr);
                end
            end
        end

        for (int i = 0; i < 6000; i++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        n_reset = 1'b0;
        en_a    = 1'b1;
        en_b    = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            scoreboard();
        end
        check("midrst_x", d0_x, 0);
        check("midrst_y", d0_y, 0);
        check("midrst_d3_hsync", d3_hs, 1);
        check("midrst_d3_vsync", d3_vs, 1);
        check("midrst_d3_on_screen", d3_on, 0);
        n_reset = 1'b1;
        scoreboard();
        check("midrst_frame_start", d0_fs, 1);

        for (int c = 1; c <= 1600; c++) begin
            step((c % 2) == 0, 1'($urandom_range(1)));
            if (c == 1599) begin
                check("toggle_1599_x", d0_x, 799);
                check("toggle_1599_y", d0_y, 0);
            end
            if (c == 1600) begin
                check("toggle_1600_x", d0_x, 0);
                check("toggle_1600_y", d0_y, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
